// File: rtl/hilo_mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// FSM states, default datapath width and small op-decode helpers.
package hilo_mdu_pkg;

  localparam int DW_DEF = 32;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

  // True for the four ops that run the iterative engine.
  function automatic logic op_is_muldiv(input logic [2:0] op);
    return (op < 3'd4);
  endfunction

  // True for the ops whose operands are treated as two's complement.
  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

  // True for the two divide ops.
  function automatic logic op_is_div(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/hilo_mdu_iter.sv
// Iterative unsigned multiply/divide datapath for hilo_mdu.
// Multiply: shift-add with a left-shifting multiplicand and right-shifting
// multiplier, so the product is always aligned and can stop early.
// Divide: restoring division; acc holds {remainder, quotient/dividend}.
// Optional macro MDU_EARLY_OUT_EN: multiply raises 'last' as soon as the
// remaining multiplier bits are all zero (at least one iteration).
module mdu_iter
  import hilo_mdu_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int CNT_W = $clog2(DW) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          step,
  input  logic          is_div,
  input  logic [DW-1:0] mag_a,
  input  logic [DW-1:0] mag_b,
  output logic          last,
  output logic [DW-1:0] res_hi,
  output logic [DW-1:0] res_lo
);

  logic [2*DW-1:0] acc_r;
  logic [2*DW-1:0] mcand_r;
  logic [DW-1:0]   opb_r;
  logic [CNT_W-1:0] cnt_r;
  logic            div_r;

  logic [2*DW-1:0] mul_acc_s;
  logic [2*DW-1:0] div_acc_s;
  logic [DW:0]     part_s;
  logic            borrow_s;
  logic [DW-1:0]   diff_s;

  // One iteration of each algorithm, computed from the current state.
  always_comb begin
    mul_acc_s = acc_r;
    if (opb_r[0]) begin
      mul_acc_s = acc_r + mcand_r;
    end else begin
      mul_acc_s = acc_r;
    end
    // Remainder shifted left with the next dividend bit brought in.
    part_s   = acc_r[2*DW-1:DW-1];
    borrow_s = (part_s < {1'b0, opb_r});
    diff_s   = part_s[DW-1:0] - opb_r;
    if (borrow_s) begin
      div_acc_s = {part_s[DW-1:0], acc_r[DW-2:0], 1'b0};
    end else begin
      div_acc_s = {diff_s, acc_r[DW-2:0], 1'b1};
    end
  end

  // Final-iteration detect: fixed count, or early exit for multiplies.
  always_comb begin
    last = (cnt_r == CNT_W'(DW - 1));
`ifdef MDU_EARLY_OUT_EN
    if (!div_r && (opb_r[DW-1:1] == {(DW-1){1'b0}})) begin
      last = 1'b1;
    end else begin
      last = (cnt_r == CNT_W'(DW - 1));
    end
`endif
  end

  // Operand load on start, one iteration per step.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r   <= {(2*DW){1'b0}};
      mcand_r <= {(2*DW){1'b0}};
      opb_r   <= {DW{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      div_r   <= 1'b0;
    end else if (start) begin
      acc_r   <= is_div ? {{DW{1'b0}}, mag_a} : {(2*DW){1'b0}};
      mcand_r <= {{DW{1'b0}}, mag_a};
      opb_r   <= mag_b;
      cnt_r   <= {CNT_W{1'b0}};
      div_r   <= is_div;
    end else if (step) begin
      cnt_r <= cnt_r + CNT_W'(1);
      if (div_r) begin
        acc_r <= div_acc_s;
      end else begin
        acc_r   <= mul_acc_s;
        mcand_r <= mcand_r << 1;
        opb_r   <= opb_r >> 1;
      end
    end
  end

  assign res_hi = acc_r[2*DW-1:DW];
  assign res_lo = acc_r[DW-1:0];

endmodule

// File: rtl/hilo_mdu.sv
// HI/LO register pair with iterative multiply/divide engine for the MIPS EX
// stage. Owns the IDLE/CALC/FIX FSM, operand sign handling, result sign
// correction, flush handling and the architectural HI/LO registers.
// Optional macro MDU_EARLY_OUT_EN enables multiply early termination
// (implemented in mdu_iter); results are identical either way.
module hilo_mdu
  import hilo_mdu_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int CNT_W = $clog2(DW) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          op_valid,
  input  logic [2:0]    op,
  input  logic [DW-1:0] src_a,
  input  logic [DW-1:0] src_b,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o
);

  mdu_state_e state_r, next_s;

  logic          accept_s, start_s, sgn_s;
  logic          step_s, write_s, last_s;
  logic [DW-1:0] mag_a_s, mag_b_s;
  logic [DW-1:0] res_hi_s, res_lo_s;
  logic [DW-1:0] fix_hi_s, fix_lo_s;
  logic [2*DW-1:0] prod_neg_s;

  logic          div_r, neg_q_r, neg_r_r, done_r;
  logic [DW-1:0] hi_r, lo_r;

  assign busy     = (state_r != IDLE);
  assign accept_s = op_valid & ~busy & ~flush;
  assign start_s  = accept_s & op_is_muldiv(op);
  assign sgn_s    = op_is_signed(op);

  // Operand magnitudes; unsigned ops pass through untouched.
  always_comb begin
    if (sgn_s && src_a[DW-1]) begin
      mag_a_s = {DW{1'b0}} - src_a;
    end else begin
      mag_a_s = src_a;
    end
    if (sgn_s && src_b[DW-1]) begin
      mag_b_s = {DW{1'b0}} - src_b;
    end else begin
      mag_b_s = src_b;
    end
  end

  mdu_iter #(
    .DW    (DW),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (start_s),
    .step   (step_s),
    .is_div (op_is_div(op)),
    .mag_a  (mag_a_s),
    .mag_b  (mag_b_s),
    .last   (last_s),
    .res_hi (res_hi_s),
    .res_lo (res_lo_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // FSM next-state: flush aborts CALC/FIX without a write.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) next_s = CALC;
        else         next_s = IDLE;
      end
      CALC: begin
        if (flush)       next_s = IDLE;
        else if (last_s) next_s = FIX;
        else             next_s = CALC;
      end
      FIX:     next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // FSM outputs: iterate in CALC, commit results in FIX.
  always_comb begin
    step_s  = 1'b0;
    write_s = 1'b0;
    case (state_r)
      CALC:    step_s  = ~flush;
      FIX:     write_s = ~flush;
      default: begin
        step_s  = 1'b0;
        write_s = 1'b0;
      end
    endcase
  end

  // Sign flags captured at the accept edge of a mul/div.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_r   <= 1'b0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else if (start_s) begin
      div_r   <= op_is_div(op);
      neg_q_r <= sgn_s & (src_a[DW-1] ^ src_b[DW-1]);
      neg_r_r <= sgn_s & src_a[DW-1];
    end
  end

  // Sign correction of the unsigned engine result.
  always_comb begin
    prod_neg_s = {(2*DW){1'b0}} - {res_hi_s, res_lo_s};
    fix_hi_s   = res_hi_s;
    fix_lo_s   = res_lo_s;
    if (div_r) begin
      if (neg_q_r) fix_lo_s = {DW{1'b0}} - res_lo_s;
      else         fix_lo_s = res_lo_s;
      if (neg_r_r) fix_hi_s = {DW{1'b0}} - res_hi_s;
      else         fix_hi_s = res_hi_s;
    end else begin
      if (neg_q_r) {fix_hi_s, fix_lo_s} = prod_neg_s;
      else         {fix_hi_s, fix_lo_s} = {res_hi_s, res_lo_s};
    end
  end

  // Architectural HI/LO: full mul/div writes or single-half MTHI/MTLO.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r <= {DW{1'b0}};
      lo_r <= {DW{1'b0}};
    end else if (write_s) begin
      hi_r <= fix_hi_s;
      lo_r <= fix_lo_s;
    end else if (accept_s) begin
      case (op)
        MDU_MTHI: hi_r <= src_a;
        MDU_MTLO: lo_r <= src_a;
        default: begin
          hi_r <= hi_r;
          lo_r <= lo_r;
        end
      endcase
    end
  end

  // Completion pulse, one cycle after the FIX commit edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_r <= 1'b0;
    end else begin
      done_r <= write_s;
    end
  end

  assign done = done_r;
  assign hi_o = hi_r;
  assign lo_o = lo_r;

endmodule

// File: tb/tb_hilo_mdu.sv
// Self-checking bench for hilo_mdu (DW=32): directed vector table,
// hand-written flush/reset/MT sequences and randomized ops checked
// against an arithmetic reference model.
module tb_hilo_mdu;
  import hilo_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, op_valid;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy, done;
  logic [31:0] hi_o, lo_o;

  int total = 0;
  int bad   = 0;

  hilo_mdu dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .op_valid (op_valid),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .busy     (busy),
    .done     (done),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference results from plain integer arithmetic.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] h, output logic [31:0] l);
    longint      sa, sb, q, r;
    logic [63:0] p;
    logic [31:0] qm, rm;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    h = 32'd0;
    l = 32'd0;
    case (o)
      3'd0: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; h = p[63:32]; l = p[31:0]; end
      3'd2: begin
        if (b == 32'd0) begin
          qm = 32'hFFFF_FFFF;
          rm = a[31] ? (32'd0 - a) : a;
          l  = a[31] ? (32'd0 - qm) : qm;
          h  = a[31] ? (32'd0 - rm) : rm;
        end else begin
          q = sa / sb;
          r = sa % sb;
          l = q[31:0];
          h = r[31:0];
        end
      end
      3'd3: begin
        if (b == 32'd0) begin
          l = 32'hFFFF_FFFF;
          h = a;
        end else begin
          l = a / b;
          h = a % b;
        end
      end
      default: begin h = 32'd0; l = 32'd0; end
    endcase
  endtask

  // Expected accept-to-done latency in cycles.
  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] b);
    logic [31:0] m;
    int k;
    m = b;
    k = 0;
    if (o == 3'd2 || o == 3'd3) return 33;
`ifdef MDU_EARLY_OUT_EN
    if (o == 3'd0 && b[31]) m = 32'd0 - b;
    for (int i = 0; i < 32; i++) if (m[i]) k = i;
    return k + 2;
`else
    return 33 + (k & 0) + (m == m ? 0 : 1);
`endif
  endfunction

  // Issue one op and, for mul/div, wait for done and check handshake.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] rh, output logic [31:0] rl, output int lat);
    @(negedge clk);
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    op_valid = 1'b0;
    lat = 0;
    if (o <= 3'd3) begin
      chk("busy_after_accept", {63'd0, busy}, 64'd1);
      while (!done && lat < 100) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("done_seen", {63'd0, done}, 64'd1);
      chk("busy_at_done", {63'd0, busy}, 64'd0);
      rh = hi_o; rl = lo_o;
      @(posedge clk); #1;
      chk("done_one_cycle", {63'd0, done}, 64'd0);
    end else begin
      chk("mt_no_busy", {63'd0, busy}, 64'd0);
      rh = hi_o; rl = lo_o;
    end
  endtask

  initial begin
    vec_t        vecs[10];
    logic [31:0] rh, rl, mh, ml;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int          lat, pulses;

    vecs[0] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{3'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{3'd3, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF};
    vecs[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{3'd3, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[6] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[7] = '{3'd2, 32'hFFFF_FF9C, 32'd0,         32'hFFFF_FF9C, 32'h0000_0001};
    vecs[8] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[9] = '{3'd1, 32'd5,         32'd1,         32'd0,         32'd5};

    rst = 1'b1; flush = 1'b0; op_valid = 1'b0; op = 3'd0; src_a = 32'd0; src_b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", {32'd0, hi_o}, 64'd0);
    chk("rst_lo", {32'd0, lo_o}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, rh, rl, lat);
      chk($sformatf("vec%0d_hi", i), {32'd0, rh}, {32'd0, vecs[i].hi});
      chk($sformatf("vec%0d_lo", i), {32'd0, rl}, {32'd0, vecs[i].lo});
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(exp_lat(vecs[i].op, vecs[i].b)));
    end

    // MTHI then MTLO on consecutive cycles.
    @(negedge clk);
    op_valid = 1'b1; op = MDU_MTHI; src_a = 32'h1234;
    @(posedge clk); #1;
    chk("mthi_hi", {32'd0, hi_o}, 64'h1234);
    chk("mthi_busy", {63'd0, busy}, 64'd0);
    op = MDU_MTLO; src_a = 32'h5678;
    @(posedge clk); #1;
    op_valid = 1'b0;
    chk("mtlo_lo", {32'd0, lo_o}, 64'h5678);
    chk("mtlo_hi_kept", {32'd0, hi_o}, 64'h1234);
    chk("mtlo_busy", {63'd0, busy}, 64'd0);

    // Flush a DIVU on its 10th iteration.
    @(negedge clk);
    op_valid = 1'b1; op = MDU_DIVU; src_a = 32'd1000; src_b = 32'd3;
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("flush_busy_before", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy_after", {63'd0, busy}, 64'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("flush_no_done", 64'(pulses), 64'd0);
    chk("flush_hi_kept", {32'd0, hi_o}, 64'h1234);
    chk("flush_lo_kept", {32'd0, lo_o}, 64'h5678);

    // MTLO and MULT issued with flush are dropped.
    @(negedge clk);
    flush = 1'b1; op_valid = 1'b1; op = MDU_MTLO; src_a = 32'hDEAD;
    @(posedge clk); #1;
    chk("flush_mtlo_lo", {32'd0, lo_o}, 64'h5678);
    op = MDU_MULT; src_a = 32'd3; src_b = 32'd3;
    @(posedge clk); #1;
    chk("flush_mult_busy", {63'd0, busy}, 64'd0);
    flush = 1'b0; op_valid = 1'b0;

    // Reset in the middle of a MULTU.
    @(negedge clk);
    op_valid = 1'b1; op = MDU_MULTU; src_a = 32'h0000_0123; src_b = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_busy_before", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_hi", {32'd0, hi_o}, 64'd0);
    chk("midrst_lo", {32'd0, lo_o}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);

    // Randomized mul/div against the reference model.
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(0, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 255));
      model(ro, ra, rb, mh, ml);
      do_op(ro, ra, rb, rh, rl, lat);
      chk($sformatf("rnd%0d_op%0d_hi", i, ro), {32'd0, rh}, {32'd0, mh});
      chk($sformatf("rnd%0d_op%0d_lo", i, ro), {32'd0, rl}, {32'd0, ml});
      chk($sformatf("rnd%0d_lat", i), 64'(lat), 64'(exp_lat(ro, rb)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hilo_mdu.md
Name: hilo_mdu

Overview:
Next-generation HI/LO unit for the MIPS core. It combines the architectural HI/LO register pair with an iterative multiply/divide engine and separate MTHI/MTLO writes. The width is parametrised. A start/busy/done handshake stalls the pipeline during multi-cycle ops. A flush input aborts in-flight work on exceptions. It sits in EX and is read by MFHI/MFLO.

Parameters:
DW, 32, operand and HI/LO register width.
CNT_W, $clog2(DW)+1, iteration counter width.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  abort in-flight op, drop same-cycle op
op_valid  in  1  op request
op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, others = no-op
src_a  in  DW  rs operand (dividend / multiplicand / MT data)
src_b  in  DW  rt operand (divisor / multiplier)
busy  out  1  engine occupied; pipeline stalls on busy
done  out  1  one-cycle pulse when HI/LO is written by a mul/div
hi_o  out  DW  architectural HI
lo_o  out  DW  architectural LO

Behaviour:
- Reset: hi_o=0, lo_o=0, busy=0, done=0, FSM=IDLE, counter=0, internal accumulators=0. Reset during CALC/FIX discards the op.
- Accept: op_valid & ~busy & ~flush at a rising edge.
- MTHI/MTLO: written at the accept edge. Only the named half changes. No busy, no done.
- MUL/DIV: FSM IDLE->CALC at the accept edge. The edge latches operand magnitudes and the sign flags (signed ops only), and clears counter.
- CALC: one shift-add (mul) or restoring-subtract (div) iteration per edge. After DW iterations go to FIX.
- FIX: apply sign correction. On the FIX edge, write HI/LO, assert done for one cycle, return to IDLE.
- Latency: accept at edge E0, HI/LO visible after edge E0+DW+1. busy=1 from after E0 until after edge E0+DW+1. busy is combinational on state != IDLE.
- MUL results: {HI,LO} = full 2*DW product. Signed MULT: product negated iff sign(a) != sign(b).
- DIV results: LO = quotient, HI = remainder. Signed DIV: quotient negated iff signs differ; remainder takes the dividend's sign.
- Divide by zero (decided, deterministic): LO = all ones before sign fix; HI = dividend magnitude before sign fix.
- Signed overflow: DIV(-2^(DW-1), -1) gives LO = 0x80000000, HI = 0 for DW=32.
- op_valid while busy: ignored. The bench asserts this never happens.
- Flush: at the next edge, CALC/FIX go to IDLE with no write and no done. flush together with op_valid: the op is dropped, including MTHI/MTLO. flush in IDLE: no effect.
- HI/LO are never partially updated by a mul/div.

Optional Feature:
MDU_EARLY_OUT_EN
- Defined: for MULT/MULTU, CALC exits to FIX once the remaining multiplier bits are all zero. Minimum 1 iteration. Latency = 2 + index of the highest set bit of |b|, capped at DW+1. A zero multiplier takes 1 iteration.
- Undefined: fixed DW iterations for all mul/div.
- DIV latency is unaffected either way. Results are identical either way.

Decomposition:
- Shared package: op encodings (MDU_MULT..MDU_MTLO), FSM state typedef (IDLE, CALC, FIX), DW default.
- Sub-module mdu_iter: datapath only (accumulator, shifter, add/sub, counter compare), controlled by start/step/last from the FSM.
- The top level keeps the FSM, sign handling, HI/LO registers and flush logic.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after DW+1 cycles busy=0, done pulse, HI=0xFFFFFFFE, LO=0x00000001.
- MULT a=-3, b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=100, b=0 -> LO=0xFFFFFFFF, HI=100. DIV a=0x80000000, b=-1 -> LO=0x80000000, HI=0.
- MTHI 0x1234 then MTLO 0x5678 on consecutive cycles -> HI=0x1234, LO=0x5678 after each accept edge, busy never set.
- Start DIVU, assert flush on iteration 10 -> busy drops next cycle, no done, HI/LO retain prior values. Then issue MTLO with flush=1 -> LO unchanged.
- rst asserted mid-MULT -> hi_o=lo_o=0, busy=0 after the edge. With MDU_EARLY_OUT_EN, MULTU b=1 -> done 2 cycles after accept.
